// File: rtl/if_stage_if.sv
// Fetch-stage bundle: memory-controller fetch handshake, execute redirect and decode hand-off.
// The master modport is the fetch stage itself; the slave modport is its surroundings.
interface if_stage_if;
    logic [31:0] if_raddr;
    logic [31:0] if_inst_i;
    logic        if_mem_ctrl_done;
    logic        if_cancel;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        id_ready_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;

    modport master (
        output if_raddr, if_cancel, id_valid_o, id_pc_o, id_inst_o,
        input  if_inst_i, if_mem_ctrl_done, branch_flag_i, branch_target_i, id_ready_i
    );

    modport slave (
        input  if_raddr, if_cancel, id_valid_o, id_pc_o, id_inst_o,
        output if_inst_i, if_mem_ctrl_done, branch_flag_i, branch_target_i, id_ready_i
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, 2-entry {pc, inst} skid FIFO towards decode,
// and branch redirect that flushes the FIFO and cancels any in-flight memory fetch.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    if_stage_if.master bus
);

    logic [31:0] r_pc_p0;
    logic [31:0] r_fifo_pc_p1   [2];
    logic [31:0] r_fifo_inst_p1 [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    logic        w_full;
    logic        w_valid;
    logic        w_cancel;
    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_count_nxt;

    function automatic logic [31:0] f_next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] f_align(input logic [31:0] target);
        return target & ~32'd3;
    endfunction

    assign w_full   = (r_count == 2'd2);
    assign w_valid  = (r_count != 2'd0);
    // Gating with rst keeps cancel low while reset is held, even if execute asserts a branch.
    assign w_cancel = rst & (bus.branch_flag_i | w_full);
    assign w_push   = bus.if_mem_ctrl_done & ~w_cancel;
    assign w_pop    = w_valid & bus.id_ready_i;

    always_comb begin
        w_count_nxt = r_count;
        if (bus.branch_flag_i) begin
            w_count_nxt = 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + 2'd1;
                2'b01:   w_count_nxt = r_count - 2'd1;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // p0: PC and FIFO control state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc_p0  <= RESET_PC;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            r_count <= w_count_nxt;
            if (bus.branch_flag_i) begin
                r_pc_p0  <= f_align(bus.branch_target_i);
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
            end else begin
                if (w_push) begin
                    r_pc_p0  <= f_next_pc(r_pc_p0);
                    r_wr_ptr <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
            end
        end
    end

    // p1: FIFO payload; contents are only observed through count, so no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc_p1[r_wr_ptr]   <= r_pc_p0;
            r_fifo_inst_p1[r_wr_ptr] <= bus.if_inst_i;
        end
    end

    assign bus.if_raddr   = r_pc_p0;
    assign bus.if_cancel  = w_cancel;
    assign bus.id_valid_o = w_valid;
    assign bus.id_pc_o    = w_valid ? r_fifo_pc_p1[r_rd_ptr]   : 32'd0;
    assign bus.id_inst_o  = w_valid ? r_fifo_inst_p1[r_rd_ptr] : 32'd0;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: per-cycle vector table with hand-derived expectations, a queue-based
// reference model of the fetch FIFO, and hand sequences for asynchronous reset behaviour.
module tb_if_stage;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    if_stage_if bus();

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        logic        done;
        logic [31:0] inst;
        logic        br;
        logic [31:0] tgt;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [31:0] e_raddr;
        logic        e_cancel;
    } vec_t;

    ent_t        sb_q[$];
    logic [31:0] m_pc;
    vec_t        vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic done, input logic [31:0] inst, input logic br,
                         input logic [31:0] tgt, input logic rdy);
        bus.if_mem_ctrl_done = done;
        bus.if_inst_i        = inst;
        bus.branch_flag_i    = br;
        bus.branch_target_i  = tgt;
        bus.id_ready_i       = rdy;
    endtask

    // Compares DUT against the queue model for the current cycle, then advances the model.
    task automatic model_cycle(input logic done, input logic [31:0] inst, input logic br,
                               input logic [31:0] tgt, input logic rdy);
        logic exp_cancel;
        exp_cancel = br | (sb_q.size() == 2);
        chk("sb_cancel", {31'd0, bus.if_cancel}, {31'd0, exp_cancel});
        chk("sb_raddr", bus.if_raddr, m_pc);
        chk("sb_valid", {31'd0, bus.id_valid_o}, {31'd0, sb_q.size() != 0});
        if (sb_q.size() != 0) begin
            chk("sb_head_pc", bus.id_pc_o, sb_q[0].pc);
            chk("sb_head_inst", bus.id_inst_o, sb_q[0].inst);
        end else begin
            chk("sb_empty_pc", bus.id_pc_o, 32'd0);
            chk("sb_empty_inst", bus.id_inst_o, 32'd0);
        end
        if (br) begin
            sb_q.delete();
            m_pc = tgt & 32'hFFFF_FFFC;
        end else begin
            if (rdy && sb_q.size() != 0) void'(sb_q.pop_front());
            if (done && !exp_cancel) begin
                sb_q.push_back('{pc: m_pc, inst: inst});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic step(input logic done, input logic [31:0] inst, input logic br,
                        input logic [31:0] tgt, input logic rdy);
        @(negedge clk);
        drive(done, inst, br, tgt, rdy);
        #1;
        model_cycle(done, inst, br, tgt, rdy);
    endtask

    function automatic vec_t mk(input logic done, input logic [31:0] inst, input logic br,
                                input logic [31:0] tgt, input logic rdy, input logic ev,
                                input logic [31:0] epc, input logic [31:0] einst,
                                input logic [31:0] eraddr, input logic ecancel);
        vec_t v;
        v.done = done; v.inst = inst; v.br = br; v.tgt = tgt; v.rdy = rdy;
        v.e_valid = ev; v.e_pc = epc; v.e_inst = einst; v.e_raddr = eraddr; v.e_cancel = ecancel;
        return v;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        // Expectations are what the outputs show during the cycle, with that cycle's inputs applied.
        vecs[0]  = mk(1, 32'h11, 0, 0, 1,            0, 32'h0,        32'h0,  32'h0,        0);
        vecs[1]  = mk(1, 32'h22, 0, 0, 1,            1, 32'h0,        32'h11, 32'h4,        0);
        vecs[2]  = mk(0, 32'h0,  0, 0, 1,            1, 32'h4,        32'h22, 32'h8,        0);
        vecs[3]  = mk(0, 32'h0,  0, 0, 0,            0, 32'h0,        32'h0,  32'h8,        0);
        vecs[4]  = mk(1, 32'h33, 0, 0, 0,            0, 32'h0,        32'h0,  32'h8,        0);
        vecs[5]  = mk(1, 32'h44, 0, 0, 0,            1, 32'h8,        32'h33, 32'hC,        0);
        vecs[6]  = mk(1, 32'h55, 0, 0, 0,            1, 32'h8,        32'h33, 32'h10,       1);
        vecs[7]  = mk(0, 32'h0,  0, 0, 1,            1, 32'h8,        32'h33, 32'h10,       1);
        vecs[8]  = mk(1, 32'h66, 0, 0, 0,            1, 32'hC,        32'h44, 32'h10,       0);
        vecs[9]  = mk(1, 32'h77, 1, 32'h103, 1,      1, 32'hC,        32'h44, 32'h14,       1);
        vecs[10] = mk(0, 32'h0,  0, 0, 0,            0, 32'h0,        32'h0,  32'h100,      0);
        vecs[11] = mk(1, 32'h88, 0, 0, 0,            0, 32'h0,        32'h0,  32'h100,      0);
        vecs[12] = mk(1, 32'h99, 0, 0, 1,            1, 32'h100,      32'h88, 32'h104,      0);
        vecs[13] = mk(0, 32'h0,  0, 0, 1,            1, 32'h104,      32'h99, 32'h108,      0);
        vecs[14] = mk(0, 32'h0,  0, 0, 0,            0, 32'h0,        32'h0,  32'h108,      0);
        vecs[15] = mk(1, 32'hAA, 1, 32'hFFFF_FFFE, 0, 0, 32'h0,       32'h0,  32'h108,      1);
        vecs[16] = mk(1, 32'hBB, 0, 0, 0,            0, 32'h0,        32'h0,  32'hFFFF_FFFC, 0);
        vecs[17] = mk(0, 32'h0,  0, 0, 1,            1, 32'hFFFF_FFFC, 32'hBB, 32'h0,       0);
        vecs[18] = mk(0, 32'h0,  0, 0, 0,            0, 32'h0,        32'h0,  32'h0,        0);

        drive(0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("rst_raddr", bus.if_raddr, 32'h0);
        chk("rst_valid", {31'd0, bus.id_valid_o}, 32'd0);
        chk("rst_pc", bus.id_pc_o, 32'd0);
        chk("rst_inst", bus.id_inst_o, 32'd0);
        bus.branch_flag_i = 1'b1;
        #1;
        chk("rst_cancel_gated", {31'd0, bus.if_cancel}, 32'd0);
        bus.branch_flag_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        m_pc = 32'h0;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(vecs[i].done, vecs[i].inst, vecs[i].br, vecs[i].tgt, vecs[i].rdy);
            #1;
            chk($sformatf("v%0d_valid", i), {31'd0, bus.id_valid_o}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d_pc", i), bus.id_pc_o, vecs[i].e_pc);
            chk($sformatf("v%0d_inst", i), bus.id_inst_o, vecs[i].e_inst);
            chk($sformatf("v%0d_raddr", i), bus.if_raddr, vecs[i].e_raddr);
            chk($sformatf("v%0d_cancel", i), {31'd0, bus.if_cancel}, {31'd0, vecs[i].e_cancel});
            model_cycle(vecs[i].done, vecs[i].inst, vecs[i].br, vecs[i].tgt, vecs[i].rdy);
        end

        // Random traffic checked against the queue model only.
        for (int i = 0; i < 200; i++) begin
            logic br_r;
            br_r = ($urandom_range(0, 15) == 0);
            step($urandom_range(0, 1), $urandom, br_r, $urandom, $urandom_range(0, 1));
        end

        // Fill the FIFO, then assert reset between edges.
        step(0, 0, 1, 32'h200, 0);
        step(1, 32'hC1, 0, 0, 0);
        step(1, 32'hC2, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        #1;
        chk("full_before_rst", {31'd0, bus.if_cancel}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_valid", {31'd0, bus.id_valid_o}, 32'd0);
        chk("async_raddr", bus.if_raddr, 32'h0);
        chk("async_cancel", {31'd0, bus.if_cancel}, 32'd0);
        chk("async_pc", bus.id_pc_o, 32'd0);
        // A fetch completing while reset is held must not survive.
        drive(1, 32'hDEAD, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("rst_done_valid", {31'd0, bus.id_valid_o}, 32'd0);
        chk("rst_done_raddr", bus.if_raddr, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        sb_q.delete();
        m_pc = 32'h0;
        step(1, 32'hCC, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        #1;
        chk("post_rst_pc", bus.id_pc_o, 32'h0);
        chk("post_rst_inst", bus.id_inst_o, 32'hCC);
        chk("post_rst_raddr", bus.if_raddr, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
